// File: rtl/load_store_unit.sv
// Sequences load/store requests onto the single-port data bus with alignment checking and load extension.
// Latency: BUS_WAIT+1 cycles from accept to resp_valid (1 cycle for errored requests); one request in flight.
// Backpressure: req_ready is low outside IDLE; the requester holds its request until accepted.
module load_store_unit #(
    parameter int unsigned BUS_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_rw,
    output logic [1:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write,
    input  logic [31:0] bus_read
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(BUS_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        illegal;
    logic        in_access;
    logic [31:0] wdata_masked;
    logic [31:0] rdata_ext;

    // Flag unsupported width codes and misaligned addresses of the incoming request.
    always_comb begin
        illegal = 1'b0;
        case (req_funct3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = req_addr[0];
            3'b010:  illegal = |req_addr[1:0];
            3'b100:  illegal = req_we;
            3'b101:  illegal = req_we | req_addr[0];
            default: illegal = 1'b1;
        endcase
    end

    // Sign/zero extend the raw bus data according to the latched width code.
    always_comb begin
        rdata_ext = bus_read;
        case (f3_q)
            3'b000:  rdata_ext = {{24{bus_read[7]}}, bus_read[7:0]};
            3'b001:  rdata_ext = {{16{bus_read[15]}}, bus_read[15:0]};
            3'b100:  rdata_ext = {24'b0, bus_read[7:0]};
            3'b101:  rdata_ext = {16'b0, bus_read[15:0]};
            default: rdata_ext = bus_read;
        endcase
    end

    // Next-state logic: accept in IDLE, count bus wait states in ACCESS, single-cycle RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'b0;
                    err_d   = illegal;
                    if (illegal) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = rdata_ext;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset returns to IDLE and drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Store data masked to the access width so the bus never sees stale upper bytes.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   wdata_masked = {24'b0, wdata_q[7:0]};
            2'b01:   wdata_masked = {16'b0, wdata_q[15:0]};
            default: wdata_masked = wdata_q;
        endcase
    end

    assign in_access  = (state_q == ACCESS);
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'b0;
    assign resp_err   = resp_valid & err_q;
    assign bus_rw     = in_access & we_q;
    assign bus_len    = in_access ? f3_q[1:0] : 2'b00;
    assign bus_addr   = in_access ? addr_q : 32'b0;
    assign bus_write  = (in_access && we_q) ? wdata_masked : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance at BUS_WAIT=1 for the main traffic,
// one at BUS_WAIT=3 for back-to-back handshake timing and mid-access reset.
module tb_load_store_unit;

    localparam int unsigned W1 = 1;
    localparam int unsigned W3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // BUS_WAIT=1 instance signals
    logic        rst, req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        bus_rw;
    logic [1:0]  bus_len;
    logic [31:0] bus_addr, bus_write, bus_read;
    logic [31:0] rd_val;

    // BUS_WAIT=3 instance signals
    logic        rst_3, req_valid_3, req_ready_3, req_we_3;
    logic [2:0]  req_funct3_3;
    logic [31:0] req_addr_3, req_wdata_3;
    logic        resp_valid_3, resp_err_3;
    logic [31:0] resp_rdata_3;
    logic        bus_rw_3;
    logic [1:0]  bus_len_3;
    logic [31:0] bus_addr_3, bus_write_3, bus_read_3;

    assign bus_read   = rd_val;
    assign bus_read_3 = 32'h0000_0000;

    load_store_unit #(.BUS_WAIT(W1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr),
        .bus_write(bus_write), .bus_read(bus_read)
    );

    load_store_unit #(.BUS_WAIT(W3)) u_dut_3 (
        .clk(clk), .rst(rst_3),
        .req_valid(req_valid_3), .req_ready(req_ready_3), .req_we(req_we_3),
        .req_funct3(req_funct3_3), .req_addr(req_addr_3), .req_wdata(req_wdata_3),
        .resp_valid(resp_valid_3), .resp_rdata(resp_rdata_3), .resp_err(resp_err_3),
        .bus_rw(bus_rw_3), .bus_len(bus_len_3), .bus_addr(bus_addr_3),
        .bus_write(bus_write_3), .bus_read(bus_read_3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int resp3_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return (a[1:0] != 2'b00);
            3'b100:  return we;
            3'b101:  return we || a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] rd);
        case (f3)
            3'b000:  return {{24{rd[7]}}, rd[7:0]};
            3'b100:  return {24'h0, rd[7:0]};
            3'b001:  return {{16{rd[15]}}, rd[15:0]};
            3'b101:  return {16'h0, rd[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] model_wr(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'b000) return wd & 32'h0000_00FF;
        if (f3 == 3'b001) return wd & 32'h0000_FFFF;
        return wd;
    endfunction

    function automatic logic [31:0] model_len(input logic [2:0] f3);
        if (f3 == 3'b010) return 32'd2;
        if (f3 == 3'b001 || f3 == 3'b101) return 32'd1;
        return 32'd0;
    endfunction

    // Response monitor: pop the scoreboard on every response strobe.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    // Response counter for the BUS_WAIT=3 instance.
    always @(negedge clk) begin
        if (resp_valid_3) resp3_cnt++;
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd);
        logic err;
        exp_t e;
        err = model_err(we, f3, a);
        @(negedge clk);
        check("ready_before", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        rd_val     = rd;
        e.err   = err;
        e.rdata = (err || we) ? 32'd0 : model_ext(f3, rd);
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (err) begin
            check("err_resp_cycle1", 32'(resp_valid), 32'd1);
            check("err_bus_rw", 32'(bus_rw), 32'd0);
            check("err_bus_addr", bus_addr, 32'd0);
            @(negedge clk);
            check("err_ready_cycle2", 32'(req_ready), 32'd1);
            check("err_bus_rw_after", 32'(bus_rw), 32'd0);
        end else begin
            for (int i = 1; i <= int'(W1); i++) begin
                if (i > 1) @(negedge clk);
                check("acc_bus_rw", 32'(bus_rw), 32'(we));
                check("acc_bus_len", 32'(bus_len), model_len(f3));
                check("acc_bus_addr", bus_addr, a);
                check("acc_bus_write", bus_write, we ? model_wr(f3, wd) : 32'd0);
                check("acc_ready_low", 32'(req_ready), 32'd0);
                check("acc_no_resp", 32'(resp_valid), 32'd0);
            end
            @(negedge clk);
            check("resp_cycle", 32'(resp_valid), 32'd1);
            check("resp_bus_rw_idle", 32'(bus_rw), 32'd0);
            check("resp_bus_write_idle", bus_write, 32'd0);
            @(negedge clk);
            check("ready_back", 32'(req_ready), 32'd1);
            check("idle_bus_addr", bus_addr, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int budget;
        logic [2:0] f3_tab [6];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rd_val = 32'd0;
        rst_3 = 1'b1; req_valid_3 = 1'b0; req_we_3 = 1'b0; req_funct3_3 = 3'd0;
        req_addr_3 = 32'd0; req_wdata_3 = 32'd0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_bus_rw", 32'(bus_rw), 32'd0);
        check("rst_bus_len", 32'(bus_len), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_write", bus_write, 32'd0);
        rst = 1'b0;
        rst_3 = 1'b0;

        // Directed traffic on the BUS_WAIT=1 instance
        do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);   // LW
        do_req(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h0000_0080);   // LB
        do_req(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h0000_0080);   // LBU
        do_req(1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'h0);   // SH
        do_req(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_1111);   // LW misaligned
        do_req(1'b1, 3'b001, 32'h0000_0301, 32'h1234_5678, 32'h0);   // SH misaligned
        do_req(1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'hAAAA_8001);   // LH
        do_req(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'hAAAA_8001);   // LHU
        do_req(1'b1, 3'b000, 32'h0000_0007, 32'hAABB_CCDD, 32'h0);   // SB
        do_req(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0);   // SW
        do_req(1'b0, 3'b011, 32'h0000_0020, 32'h0, 32'h5555_5555);   // illegal width
        do_req(1'b1, 3'b100, 32'h0000_0020, 32'h1234_5678, 32'h0);   // store with BU code
        do_req(1'b0, 3'b101, 32'h0000_0033, 32'h0, 32'h0000_7FFF);   // LHU misaligned
        for (int i = 0; i < 12; i++) begin
            do_req(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 5)],
                   $urandom, $urandom, $urandom);
        end

        // Reset and request in the same cycle: reset wins
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        check("rstreq_ready", 32'(req_ready), 32'd1);
        check("rstreq_bus_len", 32'(bus_len), 32'd0);
        @(negedge clk);
        check("rstreq_no_resp", 32'(resp_valid), 32'd0);
        check("rstreq_still_idle", 32'(req_ready), 32'd1);

        // BUS_WAIT=3: back-to-back requests
        @(negedge clk);
        req_valid_3 = 1'b1; req_we_3 = 1'b0; req_funct3_3 = 3'b010; req_addr_3 = 32'h40;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("b2b_ready_low", 32'(req_ready_3), 32'd0);
        end
        @(negedge clk);
        check("b2b_ready_c5", 32'(req_ready_3), 32'd1);
        @(negedge clk);
        check("b2b_accepted_c5", 32'(req_ready_3), 32'd0);
        check("b2b_bus_len", 32'(bus_len_3), 32'd2);
        req_valid_3 = 1'b0;
        budget = 0;
        while (!req_ready_3 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("b2b_drain_timeout", 32'(budget < 20), 32'd1);
        #1;
        check("b2b_resp_count", 32'(resp3_cnt), 32'd2);

        // BUS_WAIT=3: reset during the second ACCESS cycle of an SW
        @(negedge clk);
        req_valid_3 = 1'b1; req_we_3 = 1'b1; req_funct3_3 = 3'b010;
        req_addr_3 = 32'h80; req_wdata_3 = 32'h0BAD_CAFE;
        @(negedge clk);
        req_valid_3 = 1'b0;
        check("sw_bus_rw_c1", 32'(bus_rw_3), 32'd1);
        @(negedge clk);
        check("sw_bus_write_c2", bus_write_3, 32'h0BAD_CAFE);
        rst_3 = 1'b1;
        @(negedge clk);
        rst_3 = 1'b0;
        check("rst_mid_bus_rw", 32'(bus_rw_3), 32'd0);
        check("rst_mid_ready", 32'(req_ready_3), 32'd1);
        check("rst_mid_resp", 32'(resp_valid_3), 32'd0);
        #1;
        r0 = resp3_cnt;
        repeat (10) @(negedge clk);
        #1;
        check("rst_mid_no_resp", 32'(resp3_cnt), 32'(r0));

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
